bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Parametrised successor to the fixed 4-master bus arbiter; sits between N bus masters and the shared bus mux, driving one-hot grants and the owner index that selects the master address/data paths.
- Round-robin with bus parking: the owner keeps the bus while requesting.
- Adds a hold-limit counter so a requesting master cannot starve others indefinitely.

Parameters:
- NUM_MASTERS, 4, number of masters; legal range 2..16.
- OWNER_W, 2, width of owner index; must equal ceil(log2(NUM_MASTERS)).
- MAX_HOLD, 16, maximum consecutive granted cycles while others request; 0 disables preemption; legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rest  input  1  reset, asynchronous assert, active-low (0 = reset).
- m_req  input  NUM_MASTERS  per-master bus request, bit i = master i.
- m_grnt  output  NUM_MASTERS  one-hot grant, bit i = master i owns bus.
- owner  output  OWNER_W  index of current owner.
- grnt_chg  output  1  one-cycle pulse in the first cycle a new owner is granted.

Behaviour:
- Registered state: owner (OWNER_W bits), hold_cnt (8 bits), grnt_chg.
- m_grnt is decoded combinationally from owner: exactly one bit is always set, with no all-zero state; the bus is parked on the owner.
- Reset (rest=0, asynchronous): owner=0, m_grnt=1 (master 0), hold_cnt=0, grnt_chg=0.
- Next-owner search: first i with m_req[i]=1 scanning owner+1, owner+2, ... modulo NUM_MASTERS. The current owner is excluded from the scan.
- Each rising edge evaluates the following cases in priority order:
  1. m_req[owner]=0 and another master requests: owner <= search result, hold_cnt <= 0, grnt_chg <= 1.
  2. m_req[owner]=0 and no request: owner unchanged (parked), hold_cnt <= 0, grnt_chg <= 0.
  3. m_req[owner]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and another master requests: preempt; owner <= search result, hold_cnt <= 0, grnt_chg <= 1.
  4. m_req[owner]=1 otherwise: owner kept, grnt_chg <= 0. hold_cnt increments, saturating at MAX_HOLD-1; with MAX_HOLD=0 it stays at 0.
- Latency: a request to an idle (parked, non-requesting) owner's bus is granted one cycle after m_req is sampled high.
- With MAX_HOLD=M and continuous contention, the owner holds the bus for exactly M cycles.
- Wrap-around: the scan from owner NUM_MASTERS-1 continues at 0.
- Simultaneous requests: the winner is the lowest circular distance from owner. A preempted master that keeps requesting is re-granted only after all others requesting in between.
- Ownership changes only at clock edges; m_grnt never has two bits set, including during handover.
- Reset mid-transfer: grant returns to master 0 immediately (asynchronously). Masters must abort their bus cycle.
- Out-of-range owner values cannot occur. If NUM_MASTERS is not a power of two, owner >= NUM_MASTERS is unreachable and the decode yields all-zero for it; no recovery logic is required.

Optional Feature:
- Macro: BUS_ARB_LOCK_EN.
- With it defined:
  - Extra input m_lock, width NUM_MASTERS.
  - While m_lock[owner]=1 and m_req[owner]=1, case 3 preemption is suppressed. hold_cnt still saturates, so the owner keeps the bus for atomic sequences.
  - When lock drops while hold_cnt==MAX_HOLD-1 and others request, handover occurs at the next edge.
  - m_lock of non-owners is ignored.
- Without it: the m_lock port is absent and preemption is unconditional per case 3.

Test Plan (NUM_MASTERS=4, MAX_HOLD=4 unless noted):
- Reset, then hold m_req=0000 for 10 cycles -> m_grnt=0001, owner=0, grnt_chg=0 throughout. Assert rest=0 mid-cycle while owner=2 -> m_grnt=0001 before the next edge.
- Owner 0 idle; m_req=0100 at edge N -> at N+1, m_grnt=0100, owner=2, grnt_chg=1 for one cycle. Drop req -> grant parks on 2.
- m_req=1111 held continuously from owner=0 -> grants rotate 0,1,2,3,0, each held exactly 4 cycles, with a grnt_chg pulse at each change.
- Owner=3, m_req=0011 (owner 3 not requesting) -> next owner=0 (wrap); then owner 0 drops -> owner=1.
- MAX_HOLD=0, m_req=0111 from owner=0 -> owner stays 0 indefinitely. Drop bit 0 -> owner=1 next cycle.
- BUS_ARB_LOCK_EN defined, owner=1, m_req=0011, m_lock=0010 for 10 cycles -> owner stays 1. Clear m_lock -> owner=0 at the next edge (hold_cnt saturated).

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter for NUM_MASTERS masters.
// The bus is parked on the current owner. The owner keeps the bus while it
// requests, limited by a hold counter when others are waiting.
// Optional macro BUS_ARB_LOCK_EN adds an m_lock input. A locking owner then
// keeps the bus past the hold limit.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic [NUM_MASTERS-1:0] m_req,
`ifdef BUS_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0] m_lock,
`endif
    output logic [NUM_MASTERS-1:0] m_grnt,
    output logic [OWNER_W-1:0]     owner,
    output logic                   grnt_chg
);

    // Last hold count before preemption. Unused when MAX_HOLD is 0.
    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [OWNER_W-1:0] r_owner;
    logic [7:0]         r_hold_cnt;
    logic               r_grnt_chg;

    logic [OWNER_W-1:0] w_next_owner;
    logic               w_found;
    logic               w_owner_req;
    logic               w_owner_lock;
    logic [OWNER_W-1:0] w_owner_nxt;
    logic [7:0]         w_hold_nxt;
    logic               w_chg_nxt;

    assign w_owner_req = m_req[r_owner];

`ifdef BUS_ARB_LOCK_EN
    assign w_owner_lock = m_lock[r_owner];
`else
    assign w_owner_lock = 1'b0;
`endif

    // State register: reset parks the bus on master 0 with no change pulse.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_owner    <= '0;
            r_hold_cnt <= '0;
            r_grnt_chg <= 1'b0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_grnt_chg <= w_chg_nxt;
        end
    end

    // Circular search that skips the owner. The scan runs from the farthest
    // master to the nearest, so the nearest requester overwrites the others.
    always_comb begin
        w_found      = 1'b0;
        w_next_owner = r_owner;
        for (int d = NUM_MASTERS - 1; d >= 1; d--) begin
            int idx;
            idx = (int'(r_owner) + d) % NUM_MASTERS;
            if (m_req[idx]) begin
                w_found      = 1'b1;
                w_next_owner = OWNER_W'(idx);
            end
        end
    end

    // Next-state decision. A release wins over the hold limit. The hold limit
    // preempts only when someone else is waiting and the owner is not locked.
    always_comb begin
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold_cnt;
        w_chg_nxt   = 1'b0;
        if (!w_owner_req) begin
            w_hold_nxt = '0;
            if (w_found) begin
                w_owner_nxt = w_next_owner;
                w_chg_nxt   = 1'b1;
            end
        end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST) &&
                     w_found && !w_owner_lock) begin
            w_owner_nxt = w_next_owner;
            w_hold_nxt  = '0;
            w_chg_nxt   = 1'b1;
        end else if ((MAX_HOLD != 0) && (r_hold_cnt < HOLD_LAST)) begin
            w_hold_nxt = r_hold_cnt + 8'd1;
        end
    end

    // Output decode: a one-hot grant taken straight from the owner register.
    // It can never show two bits set.
    always_comb begin
        m_grnt = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_grnt[i] = (int'(r_owner) == i);
        end
        owner    = r_owner;
        grnt_chg = r_grnt_chg;
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr.
// Instance A uses MAX_HOLD=4. Instance B uses MAX_HOLD=0.
// Expected outputs come from a behavioural model. They are queued when the
// stimulus is driven and compared after the next rising edge.
module tb_bus_arbiter_rr;

    typedef struct {
        logic [3:0] grnt;
        logic [1:0] own;
        logic       chg;
    } exp_t;

    logic       clk;
    logic       rest;
    logic [3:0] reqA, reqB, lockA, lockB;
    logic [3:0] grntA, grntB;
    logic [1:0] ownA, ownB;
    logic       chgA, chgB;

    exp_t sbA[$];
    exp_t sbB[$];

    int checks = 0;
    int errors = 0;

    int mOwnA, mHoldA, mOwnB, mHoldB;

    bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(4)) dutA (
        .clk(clk), .rest(rest), .m_req(reqA),
`ifdef BUS_ARB_LOCK_EN
        .m_lock(lockA),
`endif
        .m_grnt(grntA), .owner(ownA), .grnt_chg(chgA)
    );

    bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(0)) dutB (
        .clk(clk), .rest(rest), .m_req(reqB),
`ifdef BUS_ARB_LOCK_EN
        .m_lock(lockB),
`endif
        .m_grnt(grntB), .owner(ownB), .grnt_chg(chgB)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Behavioural arbiter model. It advances the owner, the hold count and
    // the change flag by one edge.
    task automatic modelStep(input int maxHold, input logic [3:0] req,
                             input logic [3:0] lock, inout int own,
                             inout int hold, output logic chg);
        int cand;
        logic locked;
        cand = -1;
        for (int d = 1; d < 4; d++) begin
            if (cand < 0 && req[(own + d) % 4]) cand = (own + d) % 4;
        end
`ifdef BUS_ARB_LOCK_EN
        locked = lock[own];
`else
        locked = 1'b0;
`endif
        chg = 1'b0;
        if (!req[own]) begin
            hold = 0;
            if (cand >= 0) begin
                own = cand;
                chg = 1'b1;
            end
        end else if (maxHold != 0 && hold == maxHold - 1 && cand >= 0 && !locked) begin
            own  = cand;
            hold = 0;
            chg  = 1'b1;
        end else if (maxHold != 0 && hold < maxHold - 1) begin
            hold++;
        end
    endtask

    function automatic exp_t mkExp(input int own, input logic chg);
        exp_t e;
        e.grnt = 4'b0001 << own;
        e.own  = 2'(own);
        e.chg  = chg;
        return e;
    endfunction

    // Drive one cycle of stimulus and queue the expected results. After the
    // edge, pop the queues and compare against both instances.
    task automatic applyStimulus(input logic [3:0] rA, input logic [3:0] rB,
                                 input logic [3:0] lA);
        logic c;
        exp_t e;
        reqA  = rA;
        reqB  = rB;
        lockA = lA;
        lockB = 4'b0000;
        modelStep(4, rA, lA, mOwnA, mHoldA, c);
        sbA.push_back(mkExp(mOwnA, c));
        modelStep(0, rB, 4'b0000, mOwnB, mHoldB, c);
        sbB.push_back(mkExp(mOwnB, c));
        @(posedge clk);
        #1;
        checkOutput("sbA_depth", 32'(sbA.size()), 32'd1);
        checkOutput("sbB_depth", 32'(sbB.size()), 32'd1);
        if (sbA.size() > 0) begin
            e = sbA.pop_front();
            checkOutput("A_grnt", 32'(grntA), 32'(e.grnt));
            checkOutput("A_owner", 32'(ownA), 32'(e.own));
            checkOutput("A_chg", 32'(chgA), 32'(e.chg));
        end
        if (sbB.size() > 0) begin
            e = sbB.pop_front();
            checkOutput("B_grnt", 32'(grntB), 32'(e.grnt));
            checkOutput("B_owner", 32'(ownB), 32'(e.own));
            checkOutput("B_chg", 32'(chgB), 32'(e.chg));
        end
    endtask

    task automatic modelReset();
        mOwnA = 0; mHoldA = 0; mOwnB = 0; mHoldB = 0;
        sbA.delete();
        sbB.delete();
    endtask

    // Main sequence: reset, idle, single grant, async reset, rotation,
    // wrap-around, lock, and a random soak.
    initial begin
        rest = 1'b0;
        reqA = '0; reqB = '0; lockA = '0; lockB = '0;
        modelReset();
        #12;
        checkOutput("rst_A_grnt", 32'(grntA), 32'h1);
        checkOutput("rst_A_owner", 32'(ownA), 32'h0);
        checkOutput("rst_A_chg", 32'(chgA), 32'h0);
        checkOutput("rst_B_grnt", 32'(grntB), 32'h1);
        @(negedge clk);
        rest = 1'b1;

        // Idle: the bus stays parked on master 0.
        for (int i = 0; i < 10; i++) applyStimulus(4'b0000, 4'b0000, 4'b0000);

        // A single request to an idle bus is granted after one edge.
        // The grant then stays parked on master 2.
        applyStimulus(4'b0100, 4'b0000, 4'b0000);
        checkOutput("A_grant2", 32'(grntA), 32'h4);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b0000, 4'b0000);

        // Asynchronous reset mid-cycle while master 2 owns the bus.
        #2;
        rest = 1'b0;
        #1;
        checkOutput("async_A_grnt", 32'(grntA), 32'h1);
        checkOutput("async_A_owner", 32'(ownA), 32'h0);
        modelReset();
        @(negedge clk);
        rest = 1'b1;

        // Full contention on A rotates the grant every 4 cycles.
        // On B (MAX_HOLD=0) master 0 keeps the bus while it requests.
        for (int i = 0; i < 18; i++) applyStimulus(4'b1111, 4'b0111, 4'b0000);
        checkOutput("B_parked0", 32'(ownB), 32'h0);
        applyStimulus(4'b1111, 4'b0110, 4'b0000);
        checkOutput("B_to1", 32'(ownB), 32'h1);

        // Move A to master 3. Then show the wrap to master 0 and the
        // handover to master 1.
        applyStimulus(4'b1000, 4'b0000, 4'b0000);
        applyStimulus(4'b1000, 4'b0000, 4'b0000);
        applyStimulus(4'b0011, 4'b0000, 4'b0000);
        checkOutput("A_wrap0", 32'(ownA), 32'h0);
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        checkOutput("A_to1", 32'(ownA), 32'h1);

        // Master 1 locks while master 0 also requests. With the lock feature,
        // master 1 holds the bus. Without it, the hold limit rotates it away.
        for (int i = 0; i < 10; i++) applyStimulus(4'b0011, 4'b0000, 4'b0010);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0011, 4'b0000, 4'b0000);

        // Random soak against the model.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
